iob_axi2axil_burst: RTL and testbench

Converts the full AXI4 bursts produced by the system interconnect's peripheral master port into single-beat AXI4-Lite transactions for the downstream AXI-Lite-to-IOb peripheral bridge. It sits between the interconnect and the peripheral bridge. It accepts one burst at a time, with INCR/FIXED/WRAP address generation, and rebuilds AXI4 R/B responses with correct ID, LAST and merged error status. It removes the current restriction that peripheral accesses must be single-beat.

---
 rtl/iob_axi2axil_burst_if.sv | 105 ++++++++++
 rtl/iob_axi2axil_burst.sv | 161 ++++++++++++++++
 tb/tb_iob_axi2axil_burst.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_axi2axil_burst_if.sv
// Bus bundle for the AXI4 burst to AXI4-Lite converter.
// "slave" is the converter's view; "master" is the surrounding system's view.
interface iob_axi2axil_burst_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 1,
  parameter int LEN_W  = 8
);
  // AXI4 upstream
  logic [ID_W-1:0]     s_axi_awid;
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic [LEN_W-1:0]    s_axi_awlen;
  logic [2:0]          s_axi_awsize;
  logic [1:0]          s_axi_awburst;
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wlast;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  logic [ID_W-1:0]     s_axi_bid;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  logic [ID_W-1:0]     s_axi_arid;
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic [LEN_W-1:0]    s_axi_arlen;
  logic [2:0]          s_axi_arsize;
  logic [1:0]          s_axi_arburst;
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  logic [ID_W-1:0]     s_axi_rid;
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rlast;
  logic                s_axi_rvalid;
  logic                s_axi_rready;
  // AXI4-Lite downstream
  logic [ADDR_W-1:0]   m_axil_awaddr;
  logic [2:0]          m_axil_awprot;
  logic                m_axil_awvalid;
  logic                m_axil_awready;
  logic [DATA_W-1:0]   m_axil_wdata;
  logic [DATA_W/8-1:0] m_axil_wstrb;
  logic                m_axil_wvalid;
  logic                m_axil_wready;
  logic [1:0]          m_axil_bresp;
  logic                m_axil_bvalid;
  logic                m_axil_bready;
  logic [ADDR_W-1:0]   m_axil_araddr;
  logic [2:0]          m_axil_arprot;
  logic                m_axil_arvalid;
  logic                m_axil_arready;
  logic [DATA_W-1:0]   m_axil_rdata;
  logic [1:0]          m_axil_rresp;
  logic                m_axil_rvalid;
  logic                m_axil_rready;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready,
    output m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
    input  m_axil_awready,
    output m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    input  m_axil_wready,
    input  m_axil_bresp, m_axil_bvalid,
    output m_axil_bready,
    output m_axil_araddr, m_axil_arprot, m_axil_arvalid,
    input  m_axil_arready,
    input  m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    output m_axil_rready
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready,
    input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
    output m_axil_awready,
    input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    output m_axil_wready,
    output m_axil_bresp, m_axil_bvalid,
    input  m_axil_bready,
    input  m_axil_araddr, m_axil_arprot, m_axil_arvalid,
    output m_axil_arready,
    output m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    input  m_axil_rready
  );
endinterface

// File: rtl/iob_axi2axil_burst.sv
// AXI4 burst -> single-beat AXI4-Lite converter. One burst in flight, one
// AXI-Lite transfer outstanding; every output comes straight from a flop.
module iob_axi2axil_burst #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 1,
  parameter int LEN_W  = 8
) (
  input logic                clk_i,
  input logic                rst_n_i,
  iob_axi2axil_burst_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_REQ, WR_WAIT, WR_RESP} state_t;
  localparam logic [1:0] SLVERR = 2'b10;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q, addr_nx, step, wmask;
  logic [LEN_W-1:0]    len_q, cnt_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q, acc_q, acc_mrg;
  logic                prio_wr_q, arready_q, awready_q;
  logic                arvalid_q, rready_q, rvalid_q, rlast_q;
  logic                wready_q, awvalid_q, wvalid_q, bready_q, bvalid_q;
  logic [DATA_W-1:0]   rdata_q, wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [1:0]          rresp_q, bresp_q;
  logic                last, rsv, rd_go, wr_go, pick_rd, pick_wr;

  function automatic logic [1:0] rmax(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign last    = (cnt_q == len_q);
  assign rsv     = (burst_q == 2'b11);
  assign rd_go   = arready_q && bus.s_axi_arvalid;
  assign wr_go   = awready_q && bus.s_axi_awvalid;
  assign pick_rd = bus.s_axi_arvalid && (!bus.s_axi_awvalid || !prio_wr_q);
  assign pick_wr = bus.s_axi_awvalid && !pick_rd;
  assign acc_mrg = rmax(acc_q, bus.m_axil_bresp);
  assign step    = ADDR_W'(1) << size_q;
  assign wmask   = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);

  // next beat address: FIXED holds, WRAP folds inside the aligned window, INCR/reserved step
  always_comb begin
    addr_nx = addr_q + step;
    if (burst_q == 2'b00)      addr_nx = addr_q;
    else if (burst_q == 2'b10) addr_nx = (addr_q & ~wmask) | ((addr_q + step) & wmask);
  end

  // next-state logic; a burst ends on the beat counter, never on wlast
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_go) state_d = RD_REQ; else if (wr_go) state_d = WR_DATA;
      RD_REQ:  if (bus.m_axil_arready) state_d = RD_WAIT;
      RD_WAIT: if (bus.m_axil_rvalid) state_d = RD_RESP;
      RD_RESP: if (bus.s_axi_rready) state_d = last ? IDLE : RD_REQ;
      WR_DATA: if (bus.s_axi_wvalid) state_d = WR_REQ;
      WR_REQ:  if ((!awvalid_q || bus.m_axil_awready) && (!wvalid_q || bus.m_axil_wready))
                 state_d = WR_WAIT;
      WR_WAIT: if (bus.m_axil_bvalid) state_d = last ? WR_RESP : WR_DATA;
      WR_RESP: if (bus.s_axi_bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // registered outputs and burst context; handshake strobes follow the next state
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      id_q <= '0; addr_q <= '0; len_q <= '0; cnt_q <= '0; size_q <= '0; burst_q <= '0;
      acc_q <= '0; prio_wr_q <= 1'b0; arready_q <= 1'b0; awready_q <= 1'b0;
      arvalid_q <= 1'b0; rready_q <= 1'b0; rvalid_q <= 1'b0; rlast_q <= 1'b0;
      wready_q <= 1'b0; awvalid_q <= 1'b0; wvalid_q <= 1'b0; bready_q <= 1'b0; bvalid_q <= 1'b0;
      rdata_q <= '0; rresp_q <= '0; wdata_q <= '0; wstrb_q <= '0; bresp_q <= '0;
    end else begin
      // grant one address channel for a single cycle; it is dropped again after acceptance
      arready_q <= 1'b0;
      awready_q <= 1'b0;
      if (state_q == IDLE && !arready_q && !awready_q) begin
        arready_q <= pick_rd;
        awready_q <= pick_wr;
      end
      if (rd_go) begin
        id_q <= bus.s_axi_arid; addr_q <= bus.s_axi_araddr; len_q <= bus.s_axi_arlen;
        size_q <= bus.s_axi_arsize; burst_q <= bus.s_axi_arburst;
        cnt_q <= '0; acc_q <= '0; prio_wr_q <= 1'b0;
      end
      if (wr_go) begin
        id_q <= bus.s_axi_awid; addr_q <= bus.s_axi_awaddr; len_q <= bus.s_axi_awlen;
        size_q <= bus.s_axi_awsize; burst_q <= bus.s_axi_awburst;
        cnt_q <= '0; acc_q <= '0; prio_wr_q <= 1'b1;
      end
      arvalid_q <= (state_d == RD_REQ);
      rready_q  <= (state_d == RD_WAIT);
      rvalid_q  <= (state_d == RD_RESP);
      rlast_q   <= (state_d == RD_RESP) && last;
      wready_q  <= (state_d == WR_DATA);
      bready_q  <= (state_d == WR_WAIT);
      bvalid_q  <= (state_d == WR_RESP);
      if (state_q == RD_WAIT && bus.m_axil_rvalid) begin
        rdata_q <= bus.m_axil_rdata;
        rresp_q <= rsv ? SLVERR : bus.m_axil_rresp;
      end
      if (state_q == RD_RESP && bus.s_axi_rready && !last) begin
        cnt_q  <= cnt_q + LEN_W'(1);
        addr_q <= addr_nx;
      end
      if (state_q == WR_DATA && bus.s_axi_wvalid) begin
        wdata_q <= bus.s_axi_wdata;
        wstrb_q <= bus.s_axi_wstrb;
        if (bus.s_axi_wlast != last) acc_q <= rmax(acc_q, SLVERR);
      end
      // aw and w leave independently, each on its own ready
      if (state_q == WR_DATA && state_d == WR_REQ) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
      end else if (state_q == WR_REQ) begin
        if (bus.m_axil_awready) awvalid_q <= 1'b0;
        if (bus.m_axil_wready)  wvalid_q  <= 1'b0;
      end
      if (state_q == WR_WAIT && bus.m_axil_bvalid) begin
        acc_q <= acc_mrg;
        if (last) bresp_q <= rsv ? SLVERR : acc_mrg;
        else begin
          cnt_q  <= cnt_q + LEN_W'(1);
          addr_q <= addr_nx;
        end
      end
    end
  end

  assign bus.s_axi_awready  = awready_q;
  assign bus.s_axi_wready   = wready_q;
  assign bus.s_axi_bid      = id_q;
  assign bus.s_axi_bresp    = bresp_q;
  assign bus.s_axi_bvalid   = bvalid_q;
  assign bus.s_axi_arready  = arready_q;
  assign bus.s_axi_rid      = id_q;
  assign bus.s_axi_rdata    = rdata_q;
  assign bus.s_axi_rresp    = rresp_q;
  assign bus.s_axi_rlast    = rlast_q;
  assign bus.s_axi_rvalid   = rvalid_q;
  assign bus.m_axil_awaddr  = addr_q;
  assign bus.m_axil_awprot  = 3'b000;
  assign bus.m_axil_awvalid = awvalid_q;
  assign bus.m_axil_wdata   = wdata_q;
  assign bus.m_axil_wstrb   = wstrb_q;
  assign bus.m_axil_wvalid  = wvalid_q;
  assign bus.m_axil_bready  = bready_q;
  assign bus.m_axil_araddr  = addr_q;
  assign bus.m_axil_arprot  = 3'b000;
  assign bus.m_axil_arvalid = arvalid_q;
  assign bus.m_axil_rready  = rready_q;
endmodule

// File: tb/tb_iob_axi2axil_burst.sv
// Scoreboard bench for iob_axi2axil_burst: stimulus pushes expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_iob_axi2axil_burst;
  localparam int ADDR_W = 32, DATA_W = 32, ID_W = 1, LEN_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iob_axi2axil_burst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();
  iob_axi2axil_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W))
    dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic [1:0]      resp;
    logic            last;
  } rbeat_t;

  rbeat_t      exp_r[$];
  logic [31:0] exp_ar[$];
  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [2:0]  exp_b[$];
  logic [33:0] ds_r[$];
  logic [1:0]  ds_b[$];

  int total = 0, bad = 0, cyc = 0;
  int up_mode = 0;   // 0: ready always, 1: random, 2: held low
  int ds_rnd = 0;
  int ar_first = -1, aw_first = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got=no event want=event within bound", nm);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic r_hold = 0, ar_hold = 0, aw_hold = 0, w_hold = 0, b_hold = 0;
  logic [35:0] r_prev, w_prev;
  logic [31:0] ar_prev, aw_prev;
  logic [2:0]  b_prev;
  rbeat_t      re;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      r_hold = 0; ar_hold = 0; aw_hold = 0; w_hold = 0; b_hold = 0;
    end else begin
      if (r_hold) chk("r_stable", {bus.s_axi_rvalid, bus.s_axi_rid, bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_rlast}, {1'b1, r_prev});
      if (bus.s_axi_rvalid && bus.s_axi_rready) begin
        if (exp_r.size() == 0) begin
          total++; bad++;
          $display("FAIL r_extra: got=unexpected R beat data=%0h want=none", bus.s_axi_rdata);
        end else begin
          re = exp_r.pop_front();
          chk("r_id", bus.s_axi_rid, re.id);
          chk("r_data", bus.s_axi_rdata, re.data);
          chk("r_resp", bus.s_axi_rresp, re.resp);
          chk("r_last", bus.s_axi_rlast, re.last);
        end
      end
      r_hold = bus.s_axi_rvalid && !bus.s_axi_rready;
      r_prev = {bus.s_axi_rid, bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_rlast};

      if (ar_hold) chk("ar_stable", {bus.m_axil_arvalid, bus.m_axil_araddr}, {1'b1, ar_prev});
      if (bus.m_axil_arvalid && bus.m_axil_arready) begin
        if (ar_first < 0) ar_first = cyc;
        if (exp_ar.size() == 0) begin
          total++; bad++;
          $display("FAIL ar_extra: got=araddr %0h want=none", bus.m_axil_araddr);
        end else chk("m_araddr", bus.m_axil_araddr, exp_ar.pop_front());
        chk("m_arprot", bus.m_axil_arprot, 0);
      end
      ar_hold = bus.m_axil_arvalid && !bus.m_axil_arready;
      ar_prev = bus.m_axil_araddr;

      if (aw_hold) chk("aw_stable", {bus.m_axil_awvalid, bus.m_axil_awaddr}, {1'b1, aw_prev});
      if (bus.m_axil_awvalid && bus.m_axil_awready) begin
        if (aw_first < 0) aw_first = cyc;
        if (exp_aw.size() == 0) begin
          total++; bad++;
          $display("FAIL aw_extra: got=awaddr %0h want=none", bus.m_axil_awaddr);
        end else chk("m_awaddr", bus.m_axil_awaddr, exp_aw.pop_front());
      end
      aw_hold = bus.m_axil_awvalid && !bus.m_axil_awready;
      aw_prev = bus.m_axil_awaddr;

      if (w_hold) chk("w_stable", {bus.m_axil_wvalid, bus.m_axil_wdata, bus.m_axil_wstrb}, {1'b1, w_prev});
      if (bus.m_axil_wvalid && bus.m_axil_wready) begin
        if (exp_w.size() == 0) begin
          total++; bad++;
          $display("FAIL w_extra: got=wdata %0h want=none", bus.m_axil_wdata);
        end else chk("m_wdata_strb", {bus.m_axil_wdata, bus.m_axil_wstrb}, exp_w.pop_front());
      end
      w_hold = bus.m_axil_wvalid && !bus.m_axil_wready;
      w_prev = {bus.m_axil_wdata, bus.m_axil_wstrb};

      if (b_hold) chk("b_stable", {bus.s_axi_bvalid, bus.s_axi_bid, bus.s_axi_bresp}, {1'b1, b_prev});
      if (bus.s_axi_bvalid && bus.s_axi_bready) begin
        if (exp_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_extra: got=B resp %0h want=none", bus.s_axi_bresp);
        end else chk("b_id_resp", {bus.s_axi_bid, bus.s_axi_bresp}, exp_b.pop_front());
      end
      b_hold = bus.s_axi_bvalid && !bus.s_axi_bready;
      b_prev = {bus.s_axi_bid, bus.s_axi_bresp};
    end
  end

  // ---------------- upstream R/B ready ----------------
  initial begin
    bus.s_axi_rready = 0;
    bus.s_axi_bready = 0;
    forever begin
      @(posedge clk); #1;
      bus.s_axi_rready = (up_mode == 0) ? 1'b1 : (up_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.s_axi_bready = (up_mode == 0) ? 1'b1 : (up_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // ---------------- downstream AXI-Lite slave model ----------------
  initial begin
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, in_rst, rd_pend, aw_got, w_got;
    logic [33:0] v;
    int rdly;
    rd_pend = 0; aw_got = 0; w_got = 0; rdly = 0;
    bus.m_axil_arready = 0; bus.m_axil_rvalid = 0; bus.m_axil_rdata = '0; bus.m_axil_rresp = '0;
    bus.m_axil_awready = 0; bus.m_axil_wready = 0; bus.m_axil_bvalid = 0; bus.m_axil_bresp = '0;
    forever begin
      @(negedge clk);
      ar_hs  = bus.m_axil_arvalid && bus.m_axil_arready;
      r_hs   = bus.m_axil_rvalid && bus.m_axil_rready;
      aw_hs  = bus.m_axil_awvalid && bus.m_axil_awready;
      w_hs   = bus.m_axil_wvalid && bus.m_axil_wready;
      b_hs   = bus.m_axil_bvalid && bus.m_axil_bready;
      in_rst = !rst_n;
      @(posedge clk); #1;
      if (in_rst) begin
        rd_pend = 0; aw_got = 0; w_got = 0;
        bus.m_axil_rvalid = 0; bus.m_axil_bvalid = 0;
      end else begin
        if (r_hs) bus.m_axil_rvalid = 0;
        if (b_hs) bus.m_axil_bvalid = 0;
        if (ar_hs) begin
          rd_pend = 1;
          rdly = ds_rnd ? int'($urandom_range(0, 2)) : 0;
        end
        if (rd_pend && !bus.m_axil_rvalid) begin
          if (rdly == 0) begin
            v = (ds_r.size() != 0) ? ds_r.pop_front() : '0;
            bus.m_axil_rdata = v[33:2];
            bus.m_axil_rresp = v[1:0];
            bus.m_axil_rvalid = 1;
            rd_pend = 0;
          end else rdly--;
        end
        if (aw_hs) aw_got = 1;
        if (w_hs)  w_got = 1;
        if (aw_got && w_got && !bus.m_axil_bvalid) begin
          bus.m_axil_bresp = (ds_b.size() != 0) ? ds_b.pop_front() : 2'b00;
          bus.m_axil_bvalid = 1;
          aw_got = 0; w_got = 0;
        end
      end
      bus.m_axil_arready = ds_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.m_axil_awready = ds_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.m_axil_wready  = ds_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic rd_beat(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] dsr, input logic [1:0] er, input logic lst);
    rbeat_t e;
    e.id = id; e.data = d; e.resp = er; e.last = lst;
    exp_ar.push_back(a);
    ds_r.push_back({d, dsr});
    exp_r.push_back(e);
  endtask

  task automatic wr_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] dsb);
    exp_aw.push_back(a);
    exp_w.push_back({d, s});
    ds_b.push_back(dsb);
  endtask

  task automatic issue_ar(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bt);
    int n = 0;
    @(posedge clk); #1;
    bus.s_axi_arid = id; bus.s_axi_araddr = a; bus.s_axi_arlen = len;
    bus.s_axi_arsize = sz; bus.s_axi_arburst = bt; bus.s_axi_arvalid = 1;
    forever begin
      @(negedge clk);
      if (bus.s_axi_arready) break;
      if (++n > 1000) begin fail("ar_accept_timeout"); break; end
    end
    @(posedge clk); #1;
    bus.s_axi_arvalid = 0;
  endtask

  task automatic issue_aw(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bt);
    int n = 0;
    @(posedge clk); #1;
    bus.s_axi_awid = id; bus.s_axi_awaddr = a; bus.s_axi_awlen = len;
    bus.s_axi_awsize = sz; bus.s_axi_awburst = bt; bus.s_axi_awvalid = 1;
    forever begin
      @(negedge clk);
      if (bus.s_axi_awready) break;
      if (++n > 1000) begin fail("aw_accept_timeout"); break; end
    end
    @(posedge clk); #1;
    bus.s_axi_awvalid = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic lst);
    int n = 0;
    bus.s_axi_wdata = d; bus.s_axi_wstrb = s; bus.s_axi_wlast = lst; bus.s_axi_wvalid = 1;
    forever begin
      @(negedge clk);
      if (bus.s_axi_wready) break;
      if (++n > 1000) begin fail("w_accept_timeout"); break; end
    end
    @(posedge clk); #1;
    bus.s_axi_wvalid = 0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (exp_r.size() + exp_ar.size() + exp_aw.size() + exp_w.size() + exp_b.size() != 0) begin
      @(negedge clk);
      if (++n > 3000) begin
        fail(nm);
        exp_r.delete(); exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_b.delete();
        break;
      end
    end
    repeat (6) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] wa [4];
    int n;
    wa[0] = 32'h38; wa[1] = 32'h3C; wa[2] = 32'h30; wa[3] = 32'h34;
    bus.s_axi_arvalid = 0; bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0;
    bus.s_axi_arsize = '0; bus.s_axi_arburst = '0;
    bus.s_axi_awvalid = 0; bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0;
    bus.s_axi_awsize = '0; bus.s_axi_awburst = '0;
    bus.s_axi_wvalid = 0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", {bus.s_axi_arready, bus.s_axi_awready, bus.s_axi_wready}, 0);
    chk("rst_s_valid", {bus.s_axi_rvalid, bus.s_axi_bvalid, bus.s_axi_rlast}, 0);
    chk("rst_m_valid", {bus.m_axil_arvalid, bus.m_axil_awvalid, bus.m_axil_wvalid}, 0);
    chk("rst_m_ready", {bus.m_axil_rready, bus.m_axil_bready}, 0);
    chk("rst_addr", bus.m_axil_araddr, 0);
    chk("rst_rdata", bus.s_axi_rdata, 0);
    chk("rst_id_resp", {bus.s_axi_rid, bus.s_axi_bid, bus.s_axi_rresp, bus.s_axi_bresp}, 0);
    @(posedge clk); #1 rst_n = 1;

    // single read, plus zero-wait latency from acceptance to R valid
    rd_beat(1, 32'h100, 32'hDEADBEEF, 2'b00, 2'b00, 1);
    issue_ar(1, 32'h100, 0, 2, 2'b01);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.s_axi_rvalid && n < 20);
    chk("rd_latency", n, 3);
    wait_drain("single_read_drain");

    // INCR read, beat 1 carries a downstream error that must not merge
    for (int i = 0; i < 4; i++)
      rd_beat(0, 32'h200 + 4 * i, 32'hA5000000 + i, (i == 1) ? 2'b10 : 2'b00, (i == 1) ? 2'b10 : 2'b00, i == 3);
    issue_ar(0, 32'h200, 3, 2, 2'b01);
    wait_drain("incr_read_drain");

    // WRAP read
    for (int i = 0; i < 4; i++) rd_beat(1, wa[i], 32'hC0DE0000 + i, 2'b00, 2'b00, i == 3);
    issue_ar(1, 32'h38, 3, 2, 2'b10);
    wait_drain("wrap_read_drain");

    // FIXED read
    for (int i = 0; i < 3; i++) rd_beat(0, 32'h40, 32'hF1F00000 + i, 2'b00, 2'b00, i == 2);
    issue_ar(0, 32'h40, 2, 2, 2'b00);
    wait_drain("fixed_read_drain");

    // reserved burst type: INCR addressing, every beat SLVERR
    rd_beat(1, 32'h80, 32'h11111111, 2'b00, 2'b10, 0);
    rd_beat(1, 32'h84, 32'h22222222, 2'b00, 2'b10, 1);
    issue_ar(1, 32'h80, 1, 2, 2'b11);
    wait_drain("rsv_read_drain");

    // write burst with one SLVERR beat -> single merged B
    wr_beat(32'h300, 32'hB0B00000, 4'hF, 2'b00);
    wr_beat(32'h304, 32'hB0B00001, 4'h3, 2'b10);
    wr_beat(32'h308, 32'hB0B00002, 4'hC, 2'b00);
    exp_b.push_back({1'b1, 2'b10});
    issue_aw(1, 32'h300, 2, 2, 2'b01);
    for (int i = 0; i < 3; i++)
      send_w(32'hB0B00000 + i, (i == 0) ? 4'hF : (i == 1) ? 4'h3 : 4'hC, i == 2);
    wait_drain("write_err_drain");
    repeat (20) @(negedge clk);

    // wlast placed on the wrong beat -> SLVERR although downstream is OKAY
    wr_beat(32'h400, 32'h0000AAAA, 4'hF, 2'b00);
    wr_beat(32'h404, 32'h0000BBBB, 4'hF, 2'b00);
    exp_b.push_back({1'b0, 2'b10});
    issue_aw(0, 32'h400, 1, 2, 2'b01);
    send_w(32'h0000AAAA, 4'hF, 1);
    send_w(32'h0000BBBB, 4'hF, 0);
    wait_drain("wlast_err_drain");

    // arbitration after reset with AR and AW together, random stalls everywhere
    @(posedge clk); #1 rst_n = 0;
    repeat (2) @(posedge clk); #1 rst_n = 1;
    up_mode = 1; ds_rnd = 1; ar_first = -1; aw_first = -1;
    for (int i = 0; i < 4; i++) rd_beat(0, 32'h600 + 4 * i, 32'h60000000 + i, 2'b00, 2'b00, i == 3);
    wr_beat(32'h700, 32'h70000000, 4'hF, 2'b00);
    wr_beat(32'h704, 32'h70000001, 4'h1, 2'b00);
    exp_b.push_back({1'b1, 2'b00});
    fork
      issue_ar(0, 32'h600, 3, 2, 2'b01);
      begin
        issue_aw(1, 32'h700, 1, 2, 2'b01);
        send_w(32'h70000000, 4'hF, 0);
        send_w(32'h70000001, 4'h1, 1);
      end
    join
    wait_drain("arb_drain");
    chk("arb_read_first", (ar_first >= 0 && aw_first >= 0 && ar_first < aw_first), 1);

    // stalled write burst, DECERR dominates the merge
    wr_beat(32'h800, 32'h80000000, 4'hF, 2'b00);
    wr_beat(32'h804, 32'h80000001, 4'h2, 2'b00);
    wr_beat(32'h808, 32'h80000002, 4'h4, 2'b11);
    wr_beat(32'h80C, 32'h80000003, 4'h8, 2'b00);
    exp_b.push_back({1'b0, 2'b11});
    issue_aw(0, 32'h800, 3, 2, 2'b01);
    for (int i = 0; i < 4; i++) send_w(32'h80000000 + i, 4'(1 << i) | ((i == 0) ? 4'hF : 4'h0), i == 3);
    wait_drain("stall_write_drain");

    // longest burst, len 255
    up_mode = 0; ds_rnd = 0;
    for (int i = 0; i < 256; i++) rd_beat(1, 32'h1000 + 4 * i, 32'h55000000 + i, 2'b00, 2'b00, i == 255);
    issue_ar(1, 32'h1000, 8'd255, 2, 2'b01);
    wait_drain("len255_drain");

    // reset while the first R beat of a len-3 burst is held
    up_mode = 2;
    for (int i = 0; i < 4; i++) rd_beat(0, 32'h900 + 4 * i, 32'h90000000 + i, 2'b00, 2'b00, i == 3);
    issue_ar(0, 32'h900, 3, 2, 2'b01);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.s_axi_rvalid && n < 50);
    if (!bus.s_axi_rvalid) fail("mid_rvalid_timeout");
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_valids", {bus.s_axi_rvalid, bus.s_axi_bvalid, bus.s_axi_rlast, bus.m_axil_arvalid,
                           bus.m_axil_awvalid, bus.m_axil_wvalid}, 0);
    chk("mid_rst_readys", {bus.s_axi_arready, bus.s_axi_awready, bus.s_axi_wready,
                           bus.m_axil_rready, bus.m_axil_bready}, 0);
    exp_r.delete(); exp_ar.delete(); ds_r.delete();
    @(posedge clk); #1 rst_n = 1;
    up_mode = 0;
    rd_beat(1, 32'h104, 32'h12345678, 2'b00, 2'b00, 1);
    issue_ar(1, 32'h104, 0, 2, 2'b01);
    wait_drain("post_rst_read_drain");

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=still running want=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
